reg_text_renderer: RTL and testbench

- Renders a bank of CPU registers to the VGA pixel stream as rows of hex digits, one register per row, most-significant nibble leftmost.
- Parametrised in register count, register width, screen origin and character pitch.
- Fetches each register through a synchronous read port and looks up glyph rows through an external 8x8 glyph-ROM port.
- Emits one pixel per cycle (x, y, colour, plot) to the VGA adapter; supports single-shot and continuous refresh with a start/busy/done handshake.

---
 rtl/reg_text_renderer_if.sv | 37 +++
 rtl/reg_text_renderer.sv | 141 ++++++++++++++
 tb/tb_reg_text_renderer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_text_renderer_if.sv
// Bus bundle between the register-text renderer and its host: control
// handshake, register read port, glyph-ROM port and VGA pixel stream.
interface reg_text_renderer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NX     = 10,
  parameter int unsigned NY     = 9
);
  logic              start;
  logic              continuous;
  logic [23:0]       fg_color;
  logic [23:0]       bg_color;
  logic [3:0]        reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic [7:0]        glyph_code;
  logic [2:0]        glyph_row;
  logic [7:0]        glyph_bits;
  logic [NX-1:0]     vga_x;
  logic [NY-1:0]     vga_y;
  logic [23:0]       vga_color;
  logic              plot;
  logic              busy;
  logic              done;

  // Host side: drives control, register data and glyph rows.
  modport master (
    output start, continuous, fg_color, bg_color, reg_data, glyph_bits,
    input  reg_addr, glyph_code, glyph_row, vga_x, vga_y, vga_color,
           plot, busy, done
  );

  // Renderer side.
  modport slave (
    input  start, continuous, fg_color, bg_color, reg_data, glyph_bits,
    output reg_addr, glyph_code, glyph_row, vga_x, vga_y, vga_color,
           plot, busy, done
  );
endinterface

// File: rtl/reg_text_renderer.sv
// Draws a bank of registers as rows of hex glyphs, one pixel per cycle,
// MS nibble leftmost; single-shot or continuous frame refresh.
module reg_text_renderer #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned X0        = 10,
  parameter int unsigned Y0        = 10,
  parameter int unsigned COL_PITCH = 9,
  parameter int unsigned ROW_PITCH = 15,
  parameter int unsigned NX        = 10,
  parameter int unsigned NY        = 9
) (
  input  logic                 clock,
  input  logic                 resetn,
  reg_text_renderer_if.slave   bus
);

  localparam int unsigned NUM_COLS = DATA_W / 4;
  localparam int unsigned COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [3:0]       LAST_ROW = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        px_q, px_d;
  logic [2:0]        py_q, py_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [3:0]        reg_addr_q, reg_addr_d;

  // Next-state: value_q shifts left one nibble per character, so the
  // glyph being drawn is always its top nibble.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    px_d       = px_q;
    py_d       = py_q;
    value_d    = value_q;
    reg_addr_d = reg_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_FETCH;
          row_d      = 4'd0;
          reg_addr_d = 4'd0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        value_d = bus.reg_data;
        col_d   = '0;
        px_d    = 3'd0;
        py_d    = 3'd0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        px_d = px_q + 3'd1;
        if (px_q == 3'd7) begin
          py_d = py_q + 3'd1;
          if (py_q == 3'd7) begin
            value_d = value_q << 4;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                state_d = S_DONE;
              end else begin
                row_d      = row_q + 4'd1;
                reg_addr_d = row_q + 4'd1;
                state_d    = S_FETCH;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; continuous decides.
        if (bus.continuous) begin
          state_d    = S_FETCH;
          row_d      = 4'd0;
          reg_addr_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_q      <= 4'd0;
      col_q      <= '0;
      px_q       <= 3'd0;
      py_q       <= 3'd0;
      value_q    <= '0;
      reg_addr_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      px_q       <= px_d;
      py_q       <= py_d;
      value_q    <= value_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  assign bus.reg_addr   = reg_addr_q;
  assign bus.glyph_code = {4'b0000, value_q[DATA_W-1 -: 4]};
  assign bus.glyph_row  = py_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);

  // Pixel outputs decode straight from the counters so each pixel is
  // valid in its own plot cycle; zero outside DRAW.
  always_comb begin
    bus.plot      = 1'b0;
    bus.vga_x     = '0;
    bus.vga_y     = '0;
    bus.vga_color = 24'd0;
    if (state_q == S_DRAW) begin
      bus.plot      = 1'b1;
      bus.vga_x     = NX'(X0 + 32'(col_q) * COL_PITCH + 32'(px_q));
      bus.vga_y     = NY'(Y0 + 32'(row_q) * ROW_PITCH + 32'(py_q));
      bus.vga_color = bus.glyph_bits[3'd7 - px_q] ? bus.fg_color : bus.bg_color;
    end
  end

endmodule

// File: tb/tb_reg_text_renderer.sv
// Self-checking bench for reg_text_renderer: pixel stream compared against
// a frame model computed from pixel index arithmetic.
module tb_reg_text_renderer;

  localparam int NR        = 8;
  localparam int DW        = 16;
  localparam int NC        = DW / 4;
  localparam int X0        = 10;
  localparam int Y0        = 10;
  localparam int COL_PITCH = 9;
  localparam int ROW_PITCH = 15;
  localparam int NX        = 10;
  localparam int NY        = 9;
  localparam int PLOTS     = NR * NC * 64;
  localparam int FRAME_CYC = NR * (2 + 64 * NC) + 1;

  logic clock;
  logic resetn;

  reg_text_renderer_if #(.DATA_W(DW), .NX(NX), .NY(NY)) bus ();

  reg_text_renderer #(
    .NUM_REGS(NR), .DATA_W(DW), .X0(X0), .Y0(Y0),
    .COL_PITCH(COL_PITCH), .ROW_PITCH(ROW_PITCH), .NX(NX), .NY(NY)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  logic [DW-1:0] regs [16];
  logic [7:0]    rom  [16][8];

  int vectors;
  int miscompares;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous register file and combinational glyph ROM.
  always @(posedge clock) bus.reg_data <= regs[bus.reg_addr];
  assign bus.glyph_bits = rom[bus.glyph_code[3:0]][bus.glyph_row];

  task automatic fill_rom(input bit rnd, input logic [7:0] val);
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++)
        rom[c][r] = rnd ? 8'($urandom) : val;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 16; i++) regs[i] = DW'($urandom);
  endtask

  // Runs one frame from its FETCH cycle (optionally after a start pulse)
  // and checks every plotted pixel, frame timing and the post-DONE state.
  task automatic run_frame(input bit do_start, input int mid_start_cyc,
                           input int reg_change_cyc, input logic [DW-1:0] reg_change_val,
                           input int clear_cont_cyc, input bit start_at_done,
                           output int fg_cnt);
    logic [DW-1:0] snap [NR];
    int k, cyc, done_cyc, r, rem, c, py, px, nib, ex, ey, last_x, last_y;
    logic [7:0]  bits;
    logic [23:0] ecol;
    logic done_plot, cont;
    for (int i = 0; i < NR; i++) snap[i] = regs[i];
    fg_cnt = 0;
    if (do_start) begin
      bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    k = 0; cyc = 1; done_cyc = 0; done_plot = 1'b0; last_x = -1; last_y = -1;
    while (cyc <= FRAME_CYC + 8 && done_cyc == 0) begin
      bus.start = (cyc == mid_start_cyc) || (start_at_done && cyc == FRAME_CYC);
      if (cyc == reg_change_cyc) regs[0] = reg_change_val;
      if (cyc == clear_cont_cyc) bus.continuous = 1'b0;
      if (bus.plot) begin
        vectors++;
        if (k < PLOTS) begin
          r   = k / (64 * NC);
          rem = k % (64 * NC);
          c   = rem / 64;
          py  = (rem % 64) / 8;
          px  = k % 8;
          nib = int'((snap[r] >> (4 * (NC - 1 - c))) & DW'(15));
          ex  = (X0 + c * COL_PITCH + px) % (1 << NX);
          ey  = (Y0 + r * ROW_PITCH + py) % (1 << NY);
          bits = rom[nib][py];
          ecol = bits[7 - px] ? bus.fg_color : bus.bg_color;
          if (bus.vga_x !== NX'(ex) || bus.vga_y !== NY'(ey) || bus.vga_color !== ecol ||
              bus.glyph_code !== 8'(nib) || bus.glyph_row !== 3'(py)) begin
            miscompares++;
            $display("FAIL pixel k=%0d: got x=%0d y=%0d col=%h code=%0d grow=%0d, required x=%0d y=%0d col=%h code=%0d grow=%0d",
                     k, bus.vga_x, bus.vga_y, bus.vga_color, bus.glyph_code, bus.glyph_row,
                     ex, ey, ecol, nib, py);
          end
        end else begin
          miscompares++;
          $display("FAIL extra_plot: got plot #%0d, required at most %0d", k + 1, PLOTS);
        end
        if (bus.vga_color === bus.fg_color) fg_cnt++;
        last_x = int'(bus.vga_x);
        last_y = int'(bus.vga_y);
        k++;
      end
      if (bus.done) begin
        done_cyc  = cyc;
        done_plot = bus.plot;
      end else begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    cont = bus.continuous;
    vectors++;
    if (k !== PLOTS) begin
      miscompares++;
      $display("FAIL plot_count: got %0d, required %0d", k, PLOTS);
    end
    vectors++;
    if (done_cyc !== FRAME_CYC) begin
      miscompares++;
      $display("FAIL done_cycle: got %0d (0 = none), required %0d", done_cyc, FRAME_CYC);
    end
    vectors++;
    if (done_plot !== 1'b0) begin
      miscompares++;
      $display("FAIL plot_in_done: got %b, required 0", done_plot);
    end
    vectors++;
    if (last_x !== X0 + (NC - 1) * COL_PITCH + 7 || last_y !== Y0 + (NR - 1) * ROW_PITCH + 7) begin
      miscompares++;
      $display("FAIL last_plot: got (%0d,%0d), required (%0d,%0d)", last_x, last_y,
               X0 + (NC - 1) * COL_PITCH + 7, Y0 + (NR - 1) * ROW_PITCH + 7);
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
    vectors++;
    if (cont) begin
      if (bus.busy !== 1'b1 || bus.reg_addr !== 4'd0 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL restart: got busy=%b addr=%0d plot=%b done=%b, required 1 0 0 0",
                 bus.busy, bus.reg_addr, bus.plot, bus.done);
      end
    end else begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.plot !== 1'b0 || bus.reg_addr !== 4'(NR - 1)) begin
        miscompares++;
        $display("FAIL idle_after_done: got busy=%b done=%b plot=%b addr=%0d, required 0 0 0 %0d",
                 bus.busy, bus.done, bus.plot, bus.reg_addr, NR - 1);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    vectors++;
    if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_addr !== 4'd0 ||
        bus.vga_x !== '0 || bus.vga_y !== '0 || bus.vga_color !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d col=%h, required all 0",
               bus.plot, bus.busy, bus.done, bus.reg_addr, bus.vga_x, bus.vga_y, bus.vga_color);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_first_pixel();
    int n;
    randomize_regs();
    regs[0] = 16'h1234;
    fill_rom(1'b0, 8'hFF);
    bus.continuous = 1'b0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.reg_addr !== 4'd0 || bus.plot !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_state: got busy=%b addr=%0d plot=%b, required 1 0 0", bus.busy, bus.reg_addr, bus.plot);
    end
    @(posedge clock); #1;
    vectors++;
    if (bus.plot !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latch_state: got plot=%b busy=%b, required 0 1", bus.plot, bus.busy);
    end
    @(posedge clock); #1;
    vectors++;
    if (bus.plot !== 1'b1 || bus.vga_x !== 10'd10 || bus.vga_y !== 9'd10 ||
        bus.glyph_code !== 8'd1 || bus.vga_color !== bus.fg_color) begin
      miscompares++;
      $display("FAIL first_pixel: got plot=%b (%0d,%0d) code=%0d col=%h, required 1 (10,10) 1 %h",
               bus.plot, bus.vga_x, bus.vga_y, bus.glyph_code, bus.vga_color, bus.fg_color);
    end
    repeat (64) begin @(posedge clock); #1; end
    vectors++;
    if (bus.plot !== 1'b1 || bus.vga_x !== 10'd19 || bus.glyph_code !== 8'd2) begin
      miscompares++;
      $display("FAIL second_char: got plot=%b x=%0d code=%0d, required 1 19 2", bus.plot, bus.vga_x, bus.glyph_code);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < FRAME_CYC) begin
      @(posedge clock); #1;
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL first_done: got done=%b after %0d cycles, required 1", bus.done, n);
    end
    @(posedge clock); #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL first_idle: got busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_glyph_col0();
    int fg_cnt;
    randomize_regs();
    fill_rom(1'b0, 8'h80);
    bus.continuous = 1'b0;
    run_frame(1'b1, 0, 0, '0, 0, 1'b0, fg_cnt);
    vectors++;
    if (fg_cnt !== PLOTS / 8) begin
      miscompares++;
      $display("FAIL fg_pixel_count: got %0d, required %0d", fg_cnt, PLOTS / 8);
    end
  endtask

  task automatic test_back_to_back();
    int fg_cnt;
    randomize_regs();
    fill_rom(1'b1, 8'h00);
    bus.continuous = 1'b0;
    run_frame(1'b1, 500, 0, '0, 0, 1'b1, fg_cnt);
  endtask

  task automatic test_continuous();
    int fg_cnt;
    randomize_regs();
    regs[0] = 16'h1234;
    fill_rom(1'b1, 8'h00);
    bus.continuous = 1'b1;
    run_frame(1'b1, 0, 100, 16'hABCD, 0, 1'b0, fg_cnt);
    run_frame(1'b0, 0, 0, '0, 1000, 1'b0, fg_cnt);
  endtask

  task automatic test_reset_abort();
    int fg_cnt;
    bit saw_done;
    randomize_regs();
    fill_rom(1'b1, 8'h00);
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3 * (2 + 64 * NC) + 16) begin @(posedge clock); #1; end
    vectors++;
    if (bus.plot !== 1'b1 || bus.vga_y < 9'(Y0 + 3 * ROW_PITCH)) begin
      miscompares++;
      $display("FAIL row3_drawing: got plot=%b y=%0d, required 1 and y>=%0d", bus.plot, bus.vga_y, Y0 + 3 * ROW_PITCH);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL async_abort: got plot=%b busy=%b done=%b addr=%0d, required 0 0 0 0",
               bus.plot, bus.busy, bus.done, bus.reg_addr);
    end
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL abort_done: got done pulse during reset, required none");
    end
    bus.continuous = 1'b0;
    #2 resetn = 1'b1;
    @(posedge clock); #1;
    run_frame(1'b1, 0, 0, '0, 0, 1'b0, fg_cnt);
  endtask

  task automatic test_random();
    int fg_cnt;
    for (int it = 0; it < 2; it++) begin
      randomize_regs();
      fill_rom(1'b1, 8'h00);
      bus.fg_color = 24'($urandom);
      bus.bg_color = bus.fg_color ^ 24'h800001;
      bus.continuous = 1'b0;
      run_frame(1'b1, 0, 0, '0, 0, 1'b0, fg_cnt);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.fg_color   = 24'h00FF00;
    bus.bg_color   = 24'h000080;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    fill_rom(1'b0, 8'h00);

    test_reset();
    test_first_pixel();
    test_glyph_col0();
    test_back_to_back();
    test_continuous();
    test_reset_abort();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
